// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
// One iterative shift-add-3 binary-to-BCD converter shared by two requesters.
// Requester 0 is operand entry, requester 1 is the ALU result. Arbitration is
// round-robin on ties. Each conversion takes WIDTH shift cycles and ends with a
// one-cycle done pulse tagged with the requester that was served.

module bcd_conv_arbiter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [WIDTH-1:0]      bin0,
    input  logic                  req1,
    input  logic [WIDTH-1:0]      bin1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     scratch;
    logic [BW-1:0]     adjusted;
    logic [BW+WIDTH-1:0] shifted;
    logic [CW-1:0]     count;
    logic              last_served;
    logic              pick0;
    logic              pick1;
    logic              last_step;

    // Tie goes to whichever requester was not served last; a lone request always wins
    always_comb begin
        pick0 = req0 & (~req1 | last_served);
        pick1 = req1 & ~pick0;
    end

    // Add 3 to every digit that is 5 or more, then shift the whole {scratch, shreg} left
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            else
                adjusted[4*i +: 4] = scratch[4*i +: 4];
        end
        shifted   = {adjusted, shreg} << 1;
        last_step = (count == LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state: start on any grant, return to IDLE after the final shift
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick0 | pick1) state_next = SHIFT;
            SHIFT:   if (last_step)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: grants only exist in IDLE, busy covers the shift cycles
    always_comb begin
        busy = (state == SHIFT);
        gnt0 = (state == IDLE) & pick0;
        gnt1 = (state == IDLE) & pick1;
    end

    // Datapath: capture operand on grant, shift one bit per cycle, publish result on the last shift
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            scratch     <= '0;
            count       <= '0;
            last_served <= 1'b1;
            bcd         <= '0;
            done        <= 1'b0;
            done_id     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (gnt0 | gnt1) begin
                    shreg       <= gnt1 ? bin1 : bin0;
                    scratch     <= '0;
                    count       <= '0;
                    last_served <= gnt1;
                end
            end else begin
                shreg   <= shifted[WIDTH-1:0];
                scratch <= shifted[WIDTH +: BW];
                count   <= count + ONE;
                if (last_step) begin
                    bcd     <= shifted[WIDTH +: BW];
                    done    <= 1'b1;
                    done_id <= last_served;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed testbench for bcd_conv_arbiter (WIDTH=8, DIGITS=4).
// Each scenario task drives its own stimulus and checks results inline.

module tb_bcd_conv_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [7:0]  bin0;
    logic        req1;
    logic [7:0]  bin1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [15:0] bcd;

    int checks;
    int fails;
    int grants;
    int dones;
    logic mon_en;
    logic prev_done;

    bcd_conv_arbiter #(.WIDTH(8), .DIGITS(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .bin0(bin0),
        .req1(req1), .bin1(bin1),
        .gnt0(gnt0), .gnt1(gnt1),
        .busy(busy), .done(done), .done_id(done_id), .bcd(bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: hundreds, tens, ones in separate nibbles
    function automatic logic [15:0] ref_bcd(input int v);
        ref_bcd = {4'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor: no grant while busy, no back-to-back done, count grants/dones
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checks++;
            if (busy && (gnt0 || gnt1)) begin
                fails++;
                $display("[TB] FAIL gnt_while_busy: gnt0=%b gnt1=%b busy=%b required no grant", gnt0, gnt1, busy);
            end
            checks++;
            if (done && prev_done) begin
                fails++;
                $display("[TB] FAIL done_double: done high two cycles in a row, required single pulse");
            end
            if (gnt0 || gnt1) grants++;
            if (done) dones++;
        end
        prev_done = done;
    end

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = 8'd0; bin1 = 8'd0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)     begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)     begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (done_id !== 1'b0)  begin fails++; $display("[TB] FAIL reset_done_id: got %b expected 0", done_id); end
        checks++; if (bcd !== 16'h0000)  begin fails++; $display("[TB] FAIL reset_bcd: got %h expected 0000", bcd); end
        checks++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("[TB] FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
        step();
        checks++; if (busy !== 1'b0)     begin fails++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_255();
        req0 = 1'b1; bin0 = 8'd255;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("[TB] FAIL s255_gnt: got %b expected 10", {gnt0, gnt1}); end
        step();
        req0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL s255_busy T+%0d: got %b expected 1", i, busy); end
            checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL s255_early_done T+%0d: got %b expected 0", i, done); end
            step();
        end
        checks++; if (done !== 1'b1)     begin fails++; $display("[TB] FAIL s255_done: got %b expected 1", done); end
        checks++; if (bcd !== 16'h0255)  begin fails++; $display("[TB] FAIL s255_bcd: got %h expected 0255", bcd); end
        checks++; if (done_id !== 1'b0)  begin fails++; $display("[TB] FAIL s255_id: got %b expected 0", done_id); end
        checks++; if (busy !== 1'b0)     begin fails++; $display("[TB] FAIL s255_busy_end: got %b expected 0", busy); end
        step();
        checks++; if (done !== 1'b0)     begin fails++; $display("[TB] FAIL s255_done_pulse: got %b expected 0", done); end
        checks++; if (bcd !== 16'h0255)  begin fails++; $display("[TB] FAIL s255_bcd_hold: got %h expected 0255", bcd); end
    endtask

    task automatic test_boundaries();
        int          vals [6] = '{0, 9, 10, 99, 100, 199};
        logic [15:0] exps [6] = '{16'h0000, 16'h0009, 16'h0010, 16'h0099, 16'h0100, 16'h0199};
        int n;
        for (int i = 0; i < 6; i++) begin
            req1 = 1'b1; bin1 = 8'(vals[i]);
            #1;
            checks++; if (gnt1 !== 1'b1) begin fails++; $display("[TB] FAIL bnd_gnt %0d: got %b expected 1", vals[i], gnt1); end
            step();
            req1 = 1'b0;
            n = 1;
            while (!done && n < 20) begin step(); n++; end
            checks++; if (n !== 9)        begin fails++; $display("[TB] FAIL bnd_latency %0d: got %0d expected 9", vals[i], n); end
            checks++; if (bcd !== exps[i]) begin fails++; $display("[TB] FAIL bnd_bcd %0d: got %h expected %h", vals[i], bcd, exps[i]); end
            checks++; if (done_id !== 1'b1) begin fails++; $display("[TB] FAIL bnd_id %0d: got %b expected 1", vals[i], done_id); end
            step();
        end
    endtask

    task automatic test_both_held();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; bin0 = 8'd12; req1 = 1'b1; bin1 = 8'd34;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("[TB] FAIL both_first_gnt: got %b expected 10", {gnt0, gnt1}); end
        step();
        req0 = 1'b0;
        n = 1;
        while (!done && n < 20) begin step(); n++; end
        checks++; if (n !== 9)           begin fails++; $display("[TB] FAIL both_lat0: got %0d expected 9", n); end
        checks++; if (bcd !== 16'h0012)  begin fails++; $display("[TB] FAIL both_bcd0: got %h expected 0012", bcd); end
        checks++; if (done_id !== 1'b0)  begin fails++; $display("[TB] FAIL both_id0: got %b expected 0", done_id); end
        checks++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("[TB] FAIL both_gnt1_with_done: got %b expected 01", {gnt0, gnt1}); end
        step();
        req1 = 1'b0;
        n = 1;
        while (!done && n < 20) begin step(); n++; end
        checks++; if (n !== 9)           begin fails++; $display("[TB] FAIL both_lat1: got %0d expected 9", n); end
        checks++; if (bcd !== 16'h0034)  begin fails++; $display("[TB] FAIL both_bcd1: got %h expected 0034", bcd); end
        checks++; if (done_id !== 1'b1)  begin fails++; $display("[TB] FAIL both_id1: got %b expected 1", done_id); end
        req0 = 1'b1; bin0 = 8'd1; req1 = 1'b1; bin1 = 8'd2;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("[TB] FAIL both_alternate0: got %b expected 10", {gnt0, gnt1}); end
        step();
        n = 1;
        while (!done && n < 20) begin step(); n++; end
        checks++; if (bcd !== 16'h0001)  begin fails++; $display("[TB] FAIL both_bcd_alt0: got %h expected 0001", bcd); end
        checks++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("[TB] FAIL both_alternate1: got %b expected 01", {gnt0, gnt1}); end
        step();
        req0 = 1'b0; req1 = 1'b0;
        n = 1;
        while (!done && n < 20) begin step(); n++; end
        checks++; if (bcd !== 16'h0002)  begin fails++; $display("[TB] FAIL both_bcd_alt1: got %h expected 0002", bcd); end
        step();
    endtask

    task automatic test_request_during_shift();
        int n;
        req0 = 1'b1; bin0 = 8'd200;
        #1;
        checks++; if (gnt0 !== 1'b1) begin fails++; $display("[TB] FAIL mid_gnt0: got %b expected 1", gnt0); end
        step();
        req0 = 1'b0;
        n = 1;
        step(); step(); n = 3;
        req1 = 1'b1; bin1 = 8'd77;
        while (!done && n < 20) begin
            checks++; if (gnt1 !== 1'b0) begin fails++; $display("[TB] FAIL mid_gnt1_early T+%0d: got %b expected 0", n, gnt1); end
            step(); n++;
        end
        checks++; if (n !== 9)           begin fails++; $display("[TB] FAIL mid_lat0: got %0d expected 9", n); end
        checks++; if (bcd !== 16'h0200)  begin fails++; $display("[TB] FAIL mid_bcd0: got %h expected 0200", bcd); end
        checks++; if (done_id !== 1'b0)  begin fails++; $display("[TB] FAIL mid_id0: got %b expected 0", done_id); end
        checks++; if (gnt1 !== 1'b1)     begin fails++; $display("[TB] FAIL mid_gnt1: got %b expected 1", gnt1); end
        step();
        req1 = 1'b0;
        n = 1;
        while (!done && n < 20) begin step(); n++; end
        checks++; if (n !== 9)           begin fails++; $display("[TB] FAIL mid_lat1: got %0d expected 9", n); end
        checks++; if (bcd !== 16'h0077)  begin fails++; $display("[TB] FAIL mid_bcd1: got %h expected 0077", bcd); end
        checks++; if (done_id !== 1'b1)  begin fails++; $display("[TB] FAIL mid_id1: got %b expected 1", done_id); end
        step();
    endtask

    task automatic test_reset_mid_shift();
        int n;
        req0 = 1'b1; bin0 = 8'd128;
        #1;
        checks++; if (gnt0 !== 1'b1) begin fails++; $display("[TB] FAIL rmid_gnt0: got %b expected 1", gnt0); end
        step();
        req0 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)     begin fails++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (bcd !== 16'h0000)  begin fails++; $display("[TB] FAIL rmid_bcd: got %h expected 0000", bcd); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL rmid_no_done %0d: got %b expected 0", i, done); end
            step();
        end
        req1 = 1'b1; bin1 = 8'd5;
        #1;
        checks++; if (gnt1 !== 1'b1) begin fails++; $display("[TB] FAIL rmid_gnt1: got %b expected 1", gnt1); end
        step();
        req1 = 1'b0;
        n = 1;
        while (!done && n < 20) begin step(); n++; end
        checks++; if (n !== 9)           begin fails++; $display("[TB] FAIL rmid_lat: got %0d expected 9", n); end
        checks++; if (bcd !== 16'h0005)  begin fails++; $display("[TB] FAIL rmid_bcd5: got %h expected 0005", bcd); end
        checks++; if (done_id !== 1'b1)  begin fails++; $display("[TB] FAIL rmid_id: got %b expected 1", done_id); end
        step();
    endtask

    task automatic test_exhaustive();
        int n;
        int g_start;
        int d_start;
        logic who;
        g_start = grants;
        d_start = dones;
        for (int v = 0; v < 256; v++) begin
            who = v[0];
            if (who) begin req1 = 1'b1; bin1 = 8'(v); end
            else     begin req0 = 1'b1; bin0 = 8'(v); end
            #1;
            checks++;
            if ({gnt0, gnt1} !== (who ? 2'b01 : 2'b10)) begin
                fails++; $display("[TB] FAIL exh_gnt %0d: got %b expected %b", v, {gnt0, gnt1}, (who ? 2'b01 : 2'b10));
            end
            step();
            req0 = 1'b0; req1 = 1'b0;
            n = 1;
            while (!done && n < 20) begin step(); n++; end
            checks++; if (n !== 9) begin fails++; $display("[TB] FAIL exh_lat %0d: got %0d expected 9", v, n); end
            checks++; if (bcd !== ref_bcd(v)) begin fails++; $display("[TB] FAIL exh_bcd %0d: got %h expected %h", v, bcd, ref_bcd(v)); end
            checks++; if (done_id !== who) begin fails++; $display("[TB] FAIL exh_id %0d: got %b expected %b", v, done_id, who); end
        end
        step(); step();
        checks++; if (grants - g_start !== 256) begin fails++; $display("[TB] FAIL exh_grant_count: got %0d expected 256", grants - g_start); end
        checks++; if (dones - d_start !== 256)  begin fails++; $display("[TB] FAIL exh_done_count: got %0d expected 256", dones - d_start); end
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run all scenarios in order, then print the summary
    initial begin
        checks = 0; fails = 0; grants = 0; dones = 0;
        mon_en = 1'b0; prev_done = 1'b0;
        test_reset();
        mon_en = 1'b1;
        test_single_255();
        test_boundaries();
        test_both_held();
        test_request_during_shift();
        test_reset_mid_shift();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
